// File: rtl/controller_if.sv
// Control bundle between the multi-cycle controller and the accumulator datapath.
// The controller drives every strobe and select; the datapath returns the IR opcode field.
interface controller_if;
    logic [2:0] opcode;
    logic       PCWrite;
    logic       PCWriteCond;
    logic       IorD;
    logic       memRead;
    logic       memWrite;
    logic       IRWrite;
    logic       memToReg;
    logic       accWrite;
    logic       ALUSrcA;
    logic       ALUSrcB;
    logic       PCSrc;
    logic [1:0] ALUFunc;
    logic       halted;
    logic       retire;

    modport master (
        input  opcode,
        output PCWrite, PCWriteCond, IorD, memRead, memWrite, IRWrite,
               memToReg, accWrite, ALUSrcA, ALUSrcB, PCSrc, ALUFunc,
               halted, retire
    );

    modport slave (
        output opcode,
        input  PCWrite, PCWriteCond, IorD, memRead, memWrite, IRWrite,
               memToReg, accWrite, ALUSrcA, ALUSrcB, PCSrc, ALUFunc,
               halted, retire
    );
endinterface

// File: rtl/controller.sv
// Moore FSM sequencing fetch/decode/memory/execute for the 8-opcode accumulator ISA.
// Strobes decode from state (plus opcode in DECODE/EXEC) and are all forced low while rst is high.
module controller (
    input  logic         clk,
    input  logic         rst,
    controller_if.master bus,
    output logic [2:0]   dbg_state
);
    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        MEMRD  = 3'd2,
        EXEC   = 3'd3,
        MEMWR  = 3'd4,
        HALT   = 3'd5
    } state_t;

    localparam logic [2:0] OP_LDA = 3'b000;
    localparam logic [2:0] OP_STA = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_AND = 3'b100;
    localparam logic [2:0] OP_JMP = 3'b101;
    localparam logic [2:0] OP_JZ  = 3'b110;
    localparam logic [2:0] OP_HLT = 3'b111;

    localparam logic [1:0] FN_ADD  = 2'b00;
    localparam logic [1:0] FN_SUB  = 2'b01;
    localparam logic [1:0] FN_AND  = 2'b10;
    localparam logic [1:0] FN_PASS = 2'b11;

    state_t     state;
    state_t     state_nxt;

    logic       pc_write;
    logic       pc_write_cond;
    logic       ior_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       acc_write;
    logic       alu_src_a;
    logic       alu_src_b;
    logic       pc_src;
    logic [1:0] alu_func;
    logic       halted_s;
    logic       retire_s;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = FETCH;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        ior_d         = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        acc_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 1'b0;
        pc_src        = 1'b0;
        alu_func      = FN_ADD;
        halted_s      = 1'b0;
        retire_s      = 1'b0;

        case (state)
            FETCH: begin
                // IR <= mem[PC] and PC <= PC + 1 in the same cycle
                mem_read  = 1'b1;
                ir_write  = 1'b1;
                alu_src_b = 1'b1;
                pc_write  = 1'b1;
                state_nxt = DECODE;
            end

            DECODE: begin
                case (bus.opcode)
                    OP_JMP: begin
                        pc_src    = 1'b1;
                        pc_write  = 1'b1;
                        retire_s  = 1'b1;
                        state_nxt = FETCH;
                    end
                    OP_JZ: begin
                        // ACC passes through the ALU so the datapath zero flag gates the PC load
                        alu_src_a     = 1'b1;
                        alu_func      = FN_PASS;
                        pc_src        = 1'b1;
                        pc_write_cond = 1'b1;
                        retire_s      = 1'b1;
                        state_nxt     = FETCH;
                    end
                    OP_STA:  state_nxt = MEMWR;
                    OP_HLT:  state_nxt = HALT;
                    default: state_nxt = MEMRD;
                endcase
            end

            MEMRD: begin
                mem_read  = 1'b1;
                ior_d     = 1'b1;
                state_nxt = EXEC;
            end

            EXEC: begin
                acc_write = 1'b1;
                retire_s  = 1'b1;
                state_nxt = FETCH;
                case (bus.opcode)
                    OP_LDA: mem_to_reg = 1'b1;
                    OP_ADD: begin
                        alu_src_a = 1'b1;
                        alu_func  = FN_ADD;
                    end
                    OP_SUB: begin
                        alu_src_a = 1'b1;
                        alu_func  = FN_SUB;
                    end
                    OP_AND: begin
                        alu_src_a = 1'b1;
                        alu_func  = FN_AND;
                    end
                    default: ;
                endcase
            end

            MEMWR: begin
                mem_write = 1'b1;
                ior_d     = 1'b1;
                retire_s  = 1'b1;
                state_nxt = FETCH;
            end

            HALT: begin
                halted_s  = 1'b1;
                state_nxt = HALT;
            end

            default: state_nxt = FETCH;
        endcase
    end

    // Reset overrides the decode combinationally so nothing leaks out during an abort.
    assign bus.PCWrite     = pc_write      & ~rst;
    assign bus.PCWriteCond = pc_write_cond & ~rst;
    assign bus.IorD        = ior_d         & ~rst;
    assign bus.memRead     = mem_read      & ~rst;
    assign bus.memWrite    = mem_write     & ~rst;
    assign bus.IRWrite     = ir_write      & ~rst;
    assign bus.memToReg    = mem_to_reg    & ~rst;
    assign bus.accWrite    = acc_write     & ~rst;
    assign bus.ALUSrcA     = alu_src_a     & ~rst;
    assign bus.ALUSrcB     = alu_src_b     & ~rst;
    assign bus.PCSrc       = pc_src        & ~rst;
    assign bus.ALUFunc     = rst ? 2'b00 : alu_func;
    assign bus.halted      = halted_s      & ~rst;
    assign bus.retire      = retire_s      & ~rst;

    assign dbg_state = state;
endmodule

// File: tb/tb_controller.sv
// Directed bench for the accumulator controller: per-scenario tasks with hand-derived strobe vectors
// and a long random instruction stream checked against instruction lengths and strobe invariants.
module tb_controller;
    localparam logic [2:0] OP_LDA = 3'b000;
    localparam logic [2:0] OP_STA = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_AND = 3'b100;
    localparam logic [2:0] OP_JMP = 3'b101;
    localparam logic [2:0] OP_JZ  = 3'b110;
    localparam logic [2:0] OP_HLT = 3'b111;

    // Bit positions in the packed output vector below.
    localparam logic [14:0] B_PCW    = 15'h4000;
    localparam logic [14:0] B_PCWC   = 15'h2000;
    localparam logic [14:0] B_IORD   = 15'h1000;
    localparam logic [14:0] B_MRD    = 15'h0800;
    localparam logic [14:0] B_MWR    = 15'h0400;
    localparam logic [14:0] B_IRW    = 15'h0200;
    localparam logic [14:0] B_M2R    = 15'h0100;
    localparam logic [14:0] B_ACCW   = 15'h0080;
    localparam logic [14:0] B_SRCA   = 15'h0040;
    localparam logic [14:0] B_SRCB   = 15'h0020;
    localparam logic [14:0] B_PCSRC  = 15'h0010;
    localparam logic [14:0] B_FSUB   = 15'h0004;
    localparam logic [14:0] B_FAND   = 15'h0008;
    localparam logic [14:0] B_FPASS  = 15'h000C;
    localparam logic [14:0] B_HALTED = 15'h0002;
    localparam logic [14:0] B_RETIRE = 15'h0001;

    localparam logic [14:0] E_NONE   = 15'h0000;
    localparam logic [14:0] E_FETCH  = B_PCW | B_MRD | B_IRW | B_SRCB;
    localparam logic [14:0] E_JMP    = B_PCSRC | B_PCW | B_RETIRE;
    localparam logic [14:0] E_JZ     = B_SRCA | B_FPASS | B_PCSRC | B_PCWC | B_RETIRE;
    localparam logic [14:0] E_MEMRD  = B_MRD | B_IORD;
    localparam logic [14:0] E_MEMWR  = B_MWR | B_IORD | B_RETIRE;
    localparam logic [14:0] E_EX_LDA = B_ACCW | B_RETIRE | B_M2R;
    localparam logic [14:0] E_EX_ADD = B_ACCW | B_RETIRE | B_SRCA;
    localparam logic [14:0] E_EX_SUB = B_ACCW | B_RETIRE | B_SRCA | B_FSUB;
    localparam logic [14:0] E_EX_AND = B_ACCW | B_RETIRE | B_SRCA | B_FAND;
    localparam logic [14:0] E_HALT   = B_HALTED;

    // Clock and reset
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] dbg_state;

    controller_if bus ();

    controller dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.master),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    logic [14:0] outs;
    assign outs = {bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.memRead, bus.memWrite,
                   bus.IRWrite, bus.memToReg, bus.accWrite, bus.ALUSrcA, bus.ALUSrcB,
                   bus.PCSrc, bus.ALUFunc, bus.halted, bus.retire};

    int n_checks = 0;
    int n_pass   = 0;

    // Scoreboard of issued instructions awaiting their retire pulse.
    logic [2:0] exp_q[$];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, checks passed %0d of %0d", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

    // Driver tasks: a cycle starts 1 time unit after the rising edge; inputs are set, then
    // outputs are sampled 1 unit later, well clear of the next edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        next_cycle();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        next_cycle();
        rst = 1'b1;
        bus.opcode = OP_ADD;
        #1;
        n_checks++;
        if (outs !== E_NONE)
            $display("FAIL reset_outputs: got %h want %h", outs, E_NONE);
        else
            n_pass++;
        n_checks++;
        if (dbg_state !== 3'd0)
            $display("FAIL reset_state: got %0d want %0d", dbg_state, 0);
        else
            n_pass++;
    endtask

    task automatic test_add();
        logic [14:0] exp_t [5];
        exp_t = '{E_FETCH, E_NONE, E_MEMRD, E_EX_ADD, E_FETCH};
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            next_cycle();
            rst = 1'b0;
            bus.opcode = OP_ADD;
            #1;
            n_checks++;
            if (outs !== exp_t[i])
                $display("FAIL add_cycle%0d: got %h want %h", i + 1, outs, exp_t[i]);
            else
                n_pass++;
        end
    endtask

    task automatic test_sequence();
        logic [2:0]  op_t  [16];
        logic        any_t [16];
        logic [14:0] exp_t [16];
        int          ret_exp [4];
        int          ret_seen [$];
        op_t    = '{OP_LDA, OP_LDA, OP_LDA, OP_LDA, OP_STA, OP_STA, OP_STA, OP_SUB,
                    OP_SUB, OP_SUB, OP_SUB, OP_AND, OP_AND, OP_AND, OP_AND, OP_LDA};
        any_t   = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1,
                    1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        exp_t   = '{E_FETCH, E_NONE, E_MEMRD, E_EX_LDA, E_FETCH, E_NONE, E_MEMWR, E_FETCH,
                    E_NONE, E_MEMRD, E_EX_SUB, E_FETCH, E_NONE, E_MEMRD, E_EX_AND, E_FETCH};
        ret_exp = '{4, 7, 11, 15};
        apply_reset();
        for (int i = 0; i < 16; i++) begin
            next_cycle();
            rst = 1'b0;
            // Opcode is not sampled in FETCH, so scramble it there.
            bus.opcode = any_t[i] ? 3'($urandom_range(0, 7)) : op_t[i];
            #1;
            n_checks++;
            if (outs !== exp_t[i])
                $display("FAIL seq_cycle%0d: got %h want %h", i + 1, outs, exp_t[i]);
            else
                n_pass++;
            if (bus.retire === 1'b1)
                ret_seen.push_back(i + 1);
        end
        n_checks++;
        if (ret_seen.size() != 4)
            $display("FAIL seq_retire_count: got %0d want %0d", ret_seen.size(), 4);
        else begin
            n_pass++;
            for (int k = 0; k < 4; k++) begin
                n_checks++;
                if (ret_seen[k] != ret_exp[k])
                    $display("FAIL seq_retire_cycle%0d: got %0d want %0d", k, ret_seen[k], ret_exp[k]);
                else
                    n_pass++;
            end
        end
    endtask

    task automatic test_jump();
        logic [2:0]  op_t  [5];
        logic [14:0] exp_t [5];
        op_t  = '{OP_HLT, OP_JMP, OP_HLT, OP_JZ, OP_STA};
        exp_t = '{E_FETCH, E_JMP, E_FETCH, E_JZ, E_FETCH};
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            next_cycle();
            rst = 1'b0;
            bus.opcode = op_t[i];
            #1;
            n_checks++;
            if (outs !== exp_t[i])
                $display("FAIL jump_cycle%0d: got %h want %h", i + 1, outs, exp_t[i]);
            else
                n_pass++;
        end
    endtask

    task automatic test_halt();
        apply_reset();
        next_cycle();
        rst = 1'b0;
        bus.opcode = OP_HLT;
        #1;
        n_checks++;
        if (outs !== E_FETCH)
            $display("FAIL halt_fetch: got %h want %h", outs, E_FETCH);
        else
            n_pass++;
        next_cycle();
        bus.opcode = OP_HLT;
        #1;
        n_checks++;
        if (outs !== E_NONE)
            $display("FAIL halt_decode: got %h want %h", outs, E_NONE);
        else
            n_pass++;
        for (int i = 0; i < 21; i++) begin
            next_cycle();
            bus.opcode = 3'($urandom_range(0, 7));
            #1;
            n_checks++;
            if (outs !== E_HALT)
                $display("FAIL halt_hold%0d: got %h want %h", i, outs, E_HALT);
            else
                n_pass++;
        end
        next_cycle();
        rst = 1'b1;
        #1;
        n_checks++;
        if (outs !== E_NONE)
            $display("FAIL halt_reset: got %h want %h", outs, E_NONE);
        else
            n_pass++;
        next_cycle();
        rst = 1'b0;
        #1;
        n_checks++;
        if (outs !== E_FETCH)
            $display("FAIL halt_restart: got %h want %h", outs, E_FETCH);
        else
            n_pass++;
    endtask

    task automatic test_reset_mid();
        logic        rst_t [5];
        logic [14:0] exp_t [5];
        int          acc_seen;
        rst_t = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        exp_t = '{E_FETCH, E_NONE, E_NONE, E_FETCH, E_NONE};
        acc_seen = 0;
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            next_cycle();
            rst = rst_t[i];
            bus.opcode = OP_LDA;
            #1;
            if (bus.accWrite === 1'b1)
                acc_seen++;
            n_checks++;
            if (outs !== exp_t[i])
                $display("FAIL abort_cycle%0d: got %h want %h", i + 1, outs, exp_t[i]);
            else
                n_pass++;
        end
        n_checks++;
        if (acc_seen != 0)
            $display("FAIL abort_no_accwrite: got %0d want %0d", acc_seen, 0);
        else
            n_pass++;
    endtask

    task automatic test_random();
        int         cyc;
        int         n_issued;
        int         n_retired;
        logic       prev_mw;
        logic       prev_aw;
        logic [2:0] op;
        logic [2:0] popped;
        int         len;
        cyc = 0;
        n_issued = 0;
        n_retired = 0;
        prev_mw = 1'b0;
        prev_aw = 1'b0;
        exp_q.delete();
        apply_reset();
        while (cyc < 10000) begin
            op  = 3'($urandom_range(0, 6));
            len = (op == OP_JMP || op == OP_JZ) ? 2 : (op == OP_STA) ? 3 : 4;
            for (int k = 0; k < len; k++) begin
                next_cycle();
                rst = 1'b0;
                bus.opcode = (k == 0) ? 3'($urandom_range(0, 7)) : op;
                if (k == 1) begin
                    exp_q.push_back(op);
                    n_issued++;
                end
                #1;
                if (k == 0) begin
                    n_checks++;
                    if (outs !== E_FETCH)
                        $display("FAIL rnd_fetch cyc%0d: got %h want %h", cyc, outs, E_FETCH);
                    else
                        n_pass++;
                end
                n_checks++;
                if (bus.retire !== (k == len - 1))
                    $display("FAIL rnd_retire cyc%0d op%0d: got %b want %b", cyc, op, bus.retire, (k == len - 1));
                else
                    n_pass++;
                if (bus.retire === 1'b1) begin
                    n_retired++;
                    n_checks++;
                    if (exp_q.size() == 0)
                        $display("FAIL rnd_retire_unexpected cyc%0d: got retire want none", cyc);
                    else begin
                        popped = exp_q.pop_front();
                        if (popped !== op)
                            $display("FAIL rnd_retire_order cyc%0d: got op%0d want op%0d", cyc, op, popped);
                        else
                            n_pass++;
                    end
                end
                n_checks++;
                if (bus.memWrite === 1'b1 && bus.memRead === 1'b1)
                    $display("FAIL rnd_mem_excl cyc%0d: got both high want exclusive", cyc);
                else
                    n_pass++;
                n_checks++;
                if (bus.PCWrite === 1'b1 && bus.PCWriteCond === 1'b1)
                    $display("FAIL rnd_pc_excl cyc%0d: got both high want exclusive", cyc);
                else
                    n_pass++;
                n_checks++;
                if ((bus.memWrite === 1'b1 && prev_mw) || (bus.accWrite === 1'b1 && prev_aw))
                    $display("FAIL rnd_single_strobe cyc%0d: got back-to-back write want single", cyc);
                else
                    n_pass++;
                n_checks++;
                if (bus.IRWrite !== (k == 0))
                    $display("FAIL rnd_irwrite cyc%0d: got %b want %b", cyc, bus.IRWrite, (k == 0));
                else
                    n_pass++;
                prev_mw = bus.memWrite;
                prev_aw = bus.accWrite;
                cyc++;
            end
        end
        n_checks++;
        if (n_retired != n_issued)
            $display("FAIL rnd_retire_total: got %0d want %0d", n_retired, n_issued);
        else
            n_pass++;
        n_checks++;
        if (exp_q.size() != 0)
            $display("FAIL rnd_queue_drain: got %0d left want %0d", exp_q.size(), 0);
        else
            n_pass++;
    endtask

    initial begin
        bus.opcode = OP_LDA;
        rst = 1'b1;
        test_reset();
        test_add();
        test_sequence();
        test_jump();
        test_halt();
        test_reset_mid();
        test_random();
        // Final report
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/controller.md
# controller

Multi-cycle control unit for the 16-bit accumulator processor. Sits directly upstream of `datapath`: consumes its 3-bit `opcode` and drives every control strobe, mux select and ALU function code it takes. Sequences fetch, decode, memory access and execute/write-back for an 8-opcode accumulator ISA. Adds a halt state and an instruction-retire pulse for test benches.

## Interface
Parameters: none.

- `clk  input  1  system clock; all state changes on rising edge`
- `rst  input  1  synchronous, active-high reset; one clock; forces state FETCH and all outputs 0`
- `opcode  input  3  IR[15:13] from datapath; valid from the cycle after FETCH`
- `PCWrite  output  1  unconditional PC load`
- `PCWriteCond  output  1  PC load qualified by datapath ALU zero`
- `IorD  output  1  memory address select: 0 = PC, 1 = IR[12:0]`
- `memRead  output  1  memory read strobe`
- `memWrite  output  1  memory write strobe; writes ACC`
- `IRWrite  output  1  IR load from memory`
- `memToReg  output  1  ACC input select: 0 = ALU, 1 = MDR`
- `accWrite  output  1  ACC load enable`
- `ALUSrcA  output  1  ALU A: 0 = PC, 1 = ACC`
- `ALUSrcB  output  1  ALU B: 0 = MDR, 1 = constant 1`
- `PCSrc  output  1  PC input: 0 = ALU, 1 = IR`
- `ALUFunc  output  2  00 add, 01 sub, 10 and, 11 pass A`
- `halted  output  1  high while in HALT`
- `retire  output  1  one-cycle pulse in the last cycle of each instruction`

## Operation
- Opcodes: 000 LDA, 001 STA, 010 ADD, 011 SUB, 100 AND, 101 JMP, 110 JZ, 111 HLT. Operand address is IR[12:0].
- Moore FSM. Outputs are decoded from the current state only, except for the opcode-dependent fields in DECODE and EXEC. Any strobe not listed for a state is 0.
- FETCH: memRead=1, IorD=0, IRWrite=1, ALUSrcA=0, ALUSrcB=1, ALUFunc=00, PCSrc=0, PCWrite=1 (PC <= PC+1). Next state is DECODE.
- DECODE: opcode is decoded here.
  - JMP: PCSrc=1, PCWrite=1, retire=1. Next state is FETCH.
  - JZ: ALUSrcA=1, ALUFunc=11, PCSrc=1, PCWriteCond=1, retire=1. PC loads IR only when ACC==0. Next state is FETCH.
  - LDA, ADD, SUB, AND: next state is MEMRD.
  - STA: next state is MEMWR.
  - HLT: next state is HALT.
  - No strobes are asserted for the non-jump opcodes.
- MEMRD: memRead=1, IorD=1. MDR captures the data at the clock edge. Next state is EXEC.
- EXEC: accWrite=1, retire=1. Next state is FETCH.
  - LDA: memToReg=1.
  - ADD, SUB, AND: memToReg=0, ALUSrcA=1, ALUSrcB=0, ALUFunc = 00, 01 or 10 respectively.
- MEMWR: memWrite=1, IorD=1, retire=1. Next state is FETCH.
- HALT: all strobes 0, halted=1. Stays in HALT until rst. retire stays 0.
- Unused state encodings transition to FETCH with all outputs 0.
- opcode is sampled only in DECODE and EXEC; it may change at any other time without effect.

## Timing
- Reset: with rst=1 at a rising edge, state becomes FETCH.
- While rst is high, all outputs are forced to 0, including halted and retire.
- The first FETCH strobes appear in the first cycle with rst low.
- rst asserted in any state, including HALT and mid-instruction, aborts the instruction. No further memWrite or accWrite is issued. Restart is from FETCH.
- Cycles per instruction:
  - JMP, JZ: 2
  - STA: 3
  - LDA, ADD, SUB, AND: 4
  - HLT: 2 cycles to reach HALT, then stays there.
- retire is high for exactly one cycle per completed instruction, in that instruction's last cycle.
- In MEMWR and EXEC, memWrite and accWrite are single-cycle strobes; they are never asserted in back-to-back cycles.
- PCWrite and PCWriteCond are never asserted together. IRWrite is asserted only in FETCH.

## Test plan
- Reset then release, opcode=010 (ADD) held:
  - rst high: all outputs 0.
  - Following cycles: FETCH (memRead=IRWrite=PCWrite=1, ALUSrcB=1), DECODE, MEMRD (IorD=1, memRead=1), EXEC (accWrite=1, ALUSrcA=1, ALUFunc=00, retire=1), then FETCH.
- Sequence LDA, STA, SUB, AND, each opcode applied from DECODE onward:
  - retire pulses at cycles 4, 7, 11, 15 after reset release.
  - Cycle 7: memWrite=1 with IorD=1.
  - EXEC cycle of SUB: ALUFunc=01. EXEC cycle of AND: ALUFunc=10.
  - EXEC cycle of LDA: memToReg=1.
- JMP, then JZ:
  - JMP DECODE cycle: PCSrc=1, PCWrite=1, PCWriteCond=0.
  - JZ DECODE cycle: PCSrc=1, PCWriteCond=1, PCWrite=0, ALUSrcA=1, ALUFunc=11.
  - Both return to FETCH on the next cycle.
- HLT:
  - halted=1 from the third cycle onward.
  - Over 20 further cycles with random opcode: no strobe asserted and no retire.
  - Then rst for one cycle: halted=0 and FETCH strobes on the cycle after release.
- Reset mid-LDA, asserted during MEMRD:
  - accWrite never asserts.
  - After release the next cycle shows the FETCH strobe pattern.
- Randomized opcode stream over 10000 cycles, checked by assertions:
  - memWrite and memRead never high together.
  - PCWrite and PCWriteCond never high together.
  - The retire count equals the number of decoded non-HLT instructions.
